// File: rtl/mux_pkg.sv
// Shared types and helpers for the mux_scan_n channel scanner.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Select/pointer width: at least one bit even for tiny channel counts.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// Channel bus for mux_scan_n: packed inputs and controls in, selected data out.
interface mux_scan_n_if
  import mux_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 1
);
  localparam int unsigned SW = sel_w(N);

  logic [N*W-1:0] in;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           load;
  logic           hold;
  logic [W-1:0]   y;
  logic [SW-1:0]  ch;
  logic           y_valid;
  logic           wrap;
  logic           sel_err;

  modport master (
    output in, sel, mode, load, hold,
    input  y, ch, y_valid, wrap, sel_err
  );

  modport slave (
    input  in, sel, mode, load, hold,
    output y, ch, y_valid, wrap, sel_err
  );
endinterface

// File: rtl/scan_counter.sv
// Scan pointer with per-channel dwell counter; wrap is a registered pulse
// raised on the edge where the pointer moves from N-1 back to 0.
module scan_counter
  import mux_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DWELL = 1,
  localparam int unsigned SW   = sel_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic [SW-1:0] load_val,
  input  logic          hold,
  input  logic          enable,
  output logic [SW-1:0] ptr,
  output logic          wrap
);

  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [DW-1:0] dwell;
  logic          last_dwell;
  logic          last_ptr;

  assign last_dwell = (dwell == DW'(DWELL - 1));
  assign last_ptr   = (ptr == SW'(N - 1));

  // Priority: clear > load > hold > advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      dwell <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        ptr   <= '0;
        dwell <= '0;
      end else if (load) begin
        ptr   <= (32'(load_val) >= N) ? '0 : load_val;
        dwell <= '0;
      end else if (enable && !hold) begin
        if (last_dwell) begin
          dwell <= '0;
          if (last_ptr) begin
            ptr  <= '0;
            wrap <= 1'b1;
          end else begin
            ptr <= ptr + SW'(1);
          end
        end else begin
          dwell <= dwell + DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered mux with manual select or automatic round-robin scan.
module mux_scan_n
  import mux_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 1,
  parameter int unsigned DWELL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_scan_n_if.slave  bus
);

  localparam int unsigned SW = sel_w(N);

  state_t        state;
  logic [SW-1:0] ptr;
  logic          cnt_wrap;
  logic [SW-1:0] eff;
  logic          in_range;
  logic [W-1:0]  chan;

  // In MANUAL the pointer tracks sel so a later scan resumes from there.
  scan_counter #(
    .N     (N),
    .DWELL (DWELL)
  ) u_scan_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == IDLE),
    .load     ((state == MANUAL) || ((state == SCAN) && bus.load)),
    .load_val (bus.sel),
    .hold     (bus.hold),
    .enable   (state == SCAN),
    .ptr      (ptr),
    .wrap     (cnt_wrap)
  );

  assign eff      = (state == SCAN) ? ptr : bus.sel;
  assign in_range = (32'(eff) < N);

  // Out-of-range selects match no channel and yield zero data.
  always_comb begin
    chan = '0;
    for (int i = 0; i < N; i++) begin
      if (32'(eff) == 32'(i)) chan = bus.in[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus.y       <= '0;
      bus.ch      <= '0;
      bus.y_valid <= 1'b0;
      bus.wrap    <= 1'b0;
      bus.sel_err <= 1'b0;
    end else begin
      bus.wrap    <= cnt_wrap;
      bus.sel_err <= 1'b0;
      case (state)
        IDLE: state <= bus.mode ? SCAN : MANUAL;
        MANUAL, SCAN: begin
          bus.y       <= chan;
          bus.ch      <= eff;
          bus.y_valid <= 1'b1;
          bus.sel_err <= !in_range;
          if (bus.mode && (state == MANUAL))      state <= SCAN;
          else if (!bus.mode && (state == SCAN))  state <= MANUAL;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Randomized bench for mux_scan_n: two configurations against a behavioural model.
module tb_mux_scan_n;
  import mux_pkg::*;

  localparam int unsigned NA = 8, WA = 1, DA = 2;
  localparam int unsigned NB = 6, WB = 4, DB = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_scan_n_if #(.N(NA), .W(WA)) ifa ();
  mux_scan_n_if #(.N(NB), .W(WB)) ifb ();

  mux_scan_n #(.N(NA), .W(WA), .DWELL(DA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mux_scan_n #(.N(NB), .W(WB), .DWELL(DB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int checks   = 0;
  int failures = 0;

  // phase 0 = waiting out the post-reset idle cycle; wp = wrap owed next cycle
  typedef struct packed {
    int phase; int scan; int ptr; int dw; int wp;
    int y; int ch; int yv; int wrap; int err;
  } mdl_t;

  mdl_t ma, mb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic mdl_t mstep(mdl_t m, int n, int w, int dwell, logic [63:0] inv,
                                 int sel, bit mode, bit load, bit hold);
    int eff;
    if (m.phase == 0) begin
      m.phase = 1;
      m.scan  = mode ? 1 : 0;
      return m;
    end
    eff    = (m.scan != 0) ? m.ptr : sel;
    m.ch   = eff;
    m.yv   = 1;
    m.err  = (eff >= n) ? 1 : 0;
    m.y    = (eff < n) ? int'((inv >> (eff * w)) & ((64'd1 << w) - 64'd1)) : 0;
    m.wrap = m.wp;
    m.wp   = 0;
    if (m.scan == 0 || load) begin
      m.ptr = (sel >= n) ? 0 : sel;
      m.dw  = 0;
    end else if (!hold) begin
      m.dw++;
      if (m.dw == dwell) begin
        m.dw  = 0;
        m.ptr = (m.ptr + 1) % n;
        if (m.ptr == 0) m.wp = 1;
      end
    end
    m.scan = mode ? 1 : 0;
    return m;
  endfunction

  task automatic cmp(input string p, input mdl_t m, input logic [31:0] y, input logic [31:0] ch,
                     input logic [31:0] yv, input logic [31:0] wr, input logic [31:0] er);
    check({p, ".y"},       y,  32'(m.y));
    check({p, ".ch"},      ch, 32'(m.ch));
    check({p, ".y_valid"}, yv, 32'(m.yv));
    check({p, ".wrap"},    wr, 32'(m.wrap));
    check({p, ".sel_err"}, er, 32'(m.err));
  endtask

  task automatic cmp_all();
    cmp("A", ma, 32'(ifa.y), 32'(ifa.ch), 32'(ifa.y_valid), 32'(ifa.wrap), 32'(ifa.sel_err));
    cmp("B", mb, 32'(ifb.y), 32'(ifb.ch), 32'(ifb.y_valid), 32'(ifb.wrap), 32'(ifb.sel_err));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      ma = mstep(ma, NA, WA, DA, 64'(ifa.in), 32'(ifa.sel), ifa.mode, ifa.load, ifa.hold);
      mb = mstep(mb, NB, WB, DB, 64'(ifb.in), 32'(ifb.sel), ifb.mode, ifb.load, ifb.hold);
    end
    #1;
    cmp_all();
  endtask

  task automatic rnd();
    ifa.in   = 8'($urandom);
    ifb.in   = 24'($urandom);
    ifa.sel  = 3'($urandom);
    ifb.sel  = 3'($urandom);
    if ($urandom_range(15) == 0) ifa.mode = ~ifa.mode;
    if ($urandom_range(15) == 0) ifb.mode = ~ifb.mode;
    ifa.load = ($urandom_range(7) == 0);
    ifb.load = ($urandom_range(7) == 0);
    ifa.hold = ($urandom_range(3) == 0);
    ifb.hold = ($urandom_range(3) == 0);
  endtask

  initial begin
    ma = '0;
    mb = '0;
    ifa.in = 8'b11001100; ifa.sel = '0; ifa.mode = 1'b1; ifa.load = 1'b0; ifa.hold = 1'b0;
    ifb.in = 24'($urandom); ifb.sel = '0; ifb.mode = 1'b1; ifb.load = 1'b0; ifb.hold = 1'b0;
    #12;
    cmp_all();
    #1 rst_n = 1'b1;

    // Free-running scan from reset with DWELL=2: each channel shown twice.
    for (int j = 0; j < 40; j++) begin
      step();
      if (j >= 1) begin
        check("sweep.ch", 32'(ifa.ch), 32'(((j - 1) / 2) % 8));
        check("sweep.wrap", 32'(ifa.wrap), (j > 1 && ((j - 1) % 16) == 0) ? 32'd1 : 32'd0);
      end
    end

    // Load channel 3, hold it, then load beats hold.
    ifa.load = 1'b1; ifa.sel = 3'd3;
    step();
    ifa.load = 1'b0; ifa.hold = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold.ch", 32'(ifa.ch), 32'd3);
    end
    ifa.load = 1'b1; ifa.sel = 3'd6;
    step();
    ifa.load = 1'b0;
    step();
    check("loadwin.ch", 32'(ifa.ch), 32'd6);
    check("loadwin.wrap", 32'(ifa.wrap), 32'd0);
    ifa.hold = 1'b0;

    // Manual stepping on A; B drops to manual alongside.
    ifa.mode = 1'b0; ifa.in = 8'b10101010;
    ifb.mode = 1'b0; ifb.sel = 3'd1;
    step();
    for (int s = 0; s < 8; s++) begin
      ifa.sel = 3'(s);
      step();
      check("manual.y", 32'(ifa.y), 32'(s % 2));
      check("manual.ch", 32'(ifa.ch), 32'(s));
    end

    // Out-of-range select on the 6-channel instance.
    ifb.sel = 3'd7;
    step();
    check("oor.err", 32'(ifb.sel_err), 32'd1);
    check("oor.y", 32'(ifb.y), 32'd0);
    check("oor.valid", 32'(ifb.y_valid), 32'd1);
    ifb.sel = 3'd4;
    step();
    check("oor.clr", 32'(ifb.sel_err), 32'd0);
    ifb.sel = 3'd7; ifb.mode = 1'b1;
    step();
    ifb.sel = 3'd2;
    step();
    check("oor.scan_ch", 32'(ifb.ch), 32'd0);
    check("oor.scan_err", 32'(ifb.sel_err), 32'd0);

    repeat (400) begin
      rnd();
      step();
    end

    // Park A on channel 5, then reset between edges.
    ifa.mode = 1'b1; ifa.load = 1'b1; ifa.hold = 1'b0; ifa.sel = 3'd5;
    ifb.load = 1'b0; ifb.hold = 1'b0;
    step();
    ifa.load = 1'b0; ifa.hold = 1'b1;
    step();
    step();
    check("prerst.ch", 32'(ifa.ch), 32'd5);
    #3 rst_n = 1'b0;
    #1;
    ma = '0;
    mb = '0;
    cmp_all();
    #3 rst_n = 1'b1;
    step();
    check("rel.idle_valid", 32'(ifa.y_valid), 32'd0);
    step();
    check("rel.valid", 32'(ifa.y_valid), 32'd1);
    check("rel.ch", 32'(ifa.ch), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
